// File: rtl/sha1_padder.sv
// SHA-1 message padder.
// Packs a byte stream into 512-bit blocks and appends the 0x80 marker,
// zero fill and 64-bit big-endian message bit length. Each finished block
// is offered to the hash core through a valid/ready handshake. The block
// that carries the length field is flagged as the last block.
//
// state | meaning
// ------+--------------------------------------------------------------
// FILL  | accepting message bytes into the block buffer
// PAD   | one cycle: write 0x80 marker, plus the length field if it fits
// LEN   | one cycle: write the length field into an otherwise-zero block
// EMIT  | block_o offered downstream, held until block_ready_i
module sha1_padder #(
  parameter int BlockWidth = 512,
  parameter int LenWidth   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  input  logic                  byte_last_i,
  output logic                  byte_ready_o,
  output logic [BlockWidth-1:0] block_o,
  output logic                  block_valid_o,
  output logic                  block_last_o,
  input  logic                  block_ready_i
);

  localparam int NumBytes = BlockWidth / 8;
  localparam int LenBytes = LenWidth / 8;
  localparam int CntWidth = $clog2(NumBytes);
  localparam logic [CntWidth-1:0] LastIdx  = CntWidth'(NumBytes - 1);
  localparam logic [CntWidth-1:0] LenStart = CntWidth'(NumBytes - LenBytes);

  typedef enum logic [1:0] {
    StFill = 2'd0,
    StPad  = 2'd1,
    StLen  = 2'd2,
    StEmit = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            blk_q [NumBytes];
  logic [CntWidth-1:0]   byte_cnt_q;
  logic [CntWidth-1:0]   pad_pos_q;
  logic [LenWidth-1:0]   bit_len_q;
  logic                  final_q;
  logic                  pad_pending_q;
  logic                  len_pending_q;
  logic                  accept;
  logic                  transfer;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and handshake outputs; clear_i overrides every path.
  always_comb begin
    state_d       = state_q;
    byte_ready_o  = 1'b0;
    block_valid_o = 1'b0;
    accept        = 1'b0;
    transfer      = 1'b0;
    unique case (state_q)
      StFill: begin
        byte_ready_o = 1'b1;
        accept       = byte_valid_i & ~clear_i;
        if (accept) begin
          if (byte_cnt_q == LastIdx) begin
            state_d = StEmit;
          end else if (byte_last_i) begin
            state_d = StPad;
          end
        end
      end
      StPad: state_d = StEmit;
      StLen: state_d = StEmit;
      StEmit: begin
        block_valid_o = 1'b1;
        if (block_ready_i && !clear_i) begin
          transfer = 1'b1;
          if (pad_pending_q) begin
            state_d = StPad;
          end else if (len_pending_q) begin
            state_d = StLen;
          end else begin
            state_d = StFill;
          end
        end
      end
      default: state_d = StFill;
    endcase
    if (clear_i) begin
      state_d = StFill;
    end
  end

  // Block buffer, counters and pending flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumBytes; i++) blk_q[i] <= 8'h00;
      byte_cnt_q    <= '0;
      pad_pos_q     <= '0;
      bit_len_q     <= '0;
      final_q       <= 1'b0;
      pad_pending_q <= 1'b0;
      len_pending_q <= 1'b0;
    end else if (clear_i) begin
      for (int i = 0; i < NumBytes; i++) blk_q[i] <= 8'h00;
      byte_cnt_q    <= '0;
      pad_pos_q     <= '0;
      bit_len_q     <= '0;
      final_q       <= 1'b0;
      pad_pending_q <= 1'b0;
      len_pending_q <= 1'b0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (accept) begin
            blk_q[byte_cnt_q] <= byte_i;
            byte_cnt_q        <= byte_cnt_q + 1'b1;
            bit_len_q         <= bit_len_q + LenWidth'(8);
            if (byte_last_i) begin
              // A message ending on a block boundary needs a whole extra
              // block whose marker sits at byte 0.
              if (byte_cnt_q == LastIdx) begin
                pad_pending_q <= 1'b1;
              end else begin
                pad_pos_q <= byte_cnt_q + 1'b1;
              end
            end
          end
        end
        StPad: begin
          blk_q[pad_pos_q] <= 8'h80;
          if (pad_pos_q < LenStart) begin
            for (int i = 0; i < LenBytes; i++) begin
              blk_q[NumBytes-LenBytes+i] <= bit_len_q[LenWidth-1-8*i -: 8];
            end
            final_q <= 1'b1;
          end else begin
            len_pending_q <= 1'b1;
          end
        end
        StLen: begin
          for (int i = 0; i < LenBytes; i++) begin
            blk_q[NumBytes-LenBytes+i] <= bit_len_q[LenWidth-1-8*i -: 8];
          end
          final_q <= 1'b1;
        end
        StEmit: begin
          if (transfer) begin
            for (int i = 0; i < NumBytes; i++) blk_q[i] <= 8'h00;
            byte_cnt_q <= '0;
            pad_pos_q  <= '0;
            if (pad_pending_q) begin
              pad_pending_q <= 1'b0;
            end else if (len_pending_q) begin
              len_pending_q <= 1'b0;
            end else if (final_q) begin
              bit_len_q <= '0;
              final_q   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Flatten the byte buffer, byte 0 in the most significant position.
  always_comb begin
    block_o = '0;
    for (int i = 0; i < NumBytes; i++) begin
      block_o[BlockWidth-1-8*i -: 8] = blk_q[i];
    end
  end

  // The last flag is only meaningful while a block is offered.
  always_comb begin
    block_last_o = (state_q == StEmit) & final_q;
  end

endmodule

// File: tb/tb_sha1_padder.sv
// Self-checking bench for sha1_padder: a reference padder builds the
// expected blocks of each message into a scoreboard queue, a monitor pops
// and compares every transferred block, and hand-written sequences cover
// latency, backpressure, clear and asynchronous reset.
module tb_sha1_padder;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         clear_i;
  logic [7:0]   byte_i;
  logic         byte_valid_i;
  logic         byte_last_i;
  logic         byte_ready_o;
  logic [511:0] block_o;
  logic         block_valid_o;
  logic         block_last_o;
  logic         block_ready_i;

  sha1_padder #(.BlockWidth(512), .LenWidth(64)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .byte_i        (byte_i),
    .byte_valid_i  (byte_valid_i),
    .byte_last_i   (byte_last_i),
    .byte_ready_o  (byte_ready_o),
    .block_o       (block_o),
    .block_valid_o (block_valid_o),
    .block_last_o  (block_last_o),
    .block_ready_i (block_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [511:0] blk;
    logic         last;
  } exp_t;

  typedef struct {
    int         len;
    logic [7:0] seed;
    logic [7:0] step;
    int         exp_blocks;
  } vec_t;

  exp_t       exp_q[$];
  logic [7:0] msg_q[$];
  int         tests = 0;
  int         fails = 0;
  int         blocks_seen = 0;

  task automatic check_eq(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference padding: marker, zero fill to 56 mod 64, 64-bit bit length.
  function automatic void push_expected();
    logic [7:0]  q[$];
    logic [63:0] bl;
    int          nblk;
    exp_t        e;
    q  = msg_q;
    bl = 64'(msg_q.size()) * 64'd8;
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    for (int i = 0; i < 8; i++) q.push_back(bl[63-8*i -: 8]);
    nblk = q.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e.blk = '0;
      for (int k = 0; k < 64; k++) e.blk[511-8*k -: 8] = q[b*64+k];
      e.last = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endfunction

  function automatic void fill_msg(input int len, input logic [7:0] seed, input logic [7:0] step);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(seed + 8'(i) * step);
  endfunction

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_i);
      if (byte_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk_i);
    #1;
    check_eq("byte_accept_timeout", 512'(ok), 512'd1);
  endtask

  task automatic drive_bytes(input bit mark_last);
    for (int i = 0; i < msg_q.size(); i++) begin
      byte_valid_i = 1'b1;
      byte_i       = msg_q[i];
      byte_last_i  = mark_last && (i == msg_q.size() - 1);
      wait_accept();
    end
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
  endtask

  task automatic send_msg();
    push_expected();
    drive_bytes(1'b1);
  endtask

  task automatic drain();
    for (int n = 0; n < 2000; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk_i);
    end
    #1;
    check_eq("drain_timeout", 512'(exp_q.size()), 512'd0);
  endtask

  // Scoreboard monitor: a block transfers on the next edge when valid & ready.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni && !clear_i && block_valid_o && block_ready_i) begin
      blocks_seen++;
      check_eq("block_expected", 512'(exp_q.size() != 0), 512'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("block_data", block_o, e.blk);
        check_eq("block_last", 512'(block_last_o), 512'(e.last));
      end
    end
  end

  initial begin
    vec_t         vecs[10];
    logic [511:0] hold_blk;
    logic         hold_last;
    int           exp_sum;
    int           seen0;

    vecs[0] = '{3,   8'h61, 8'h01, 1};
    vecs[1] = '{55,  8'h00, 8'h00, 1};
    vecs[2] = '{56,  8'h00, 8'h00, 2};
    vecs[3] = '{64,  8'h11, 8'h03, 2};
    vecs[4] = '{1,   8'h5a, 8'h00, 1};
    vecs[5] = '{63,  8'h20, 8'h05, 2};
    vecs[6] = '{65,  8'hc3, 8'h07, 2};
    vecs[7] = '{119, 8'h01, 8'h0b, 2};
    vecs[8] = '{120, 8'h77, 8'h0d, 3};
    vecs[9] = '{128, 8'h9e, 8'h11, 3};

    rst_ni        = 1'b0;
    clear_i       = 1'b0;
    byte_i        = 8'h00;
    byte_valid_i  = 1'b0;
    byte_last_i   = 1'b0;
    block_ready_i = 1'b1;

    repeat (2) @(negedge clk_i);
    check_eq("rst_byte_ready", 512'(byte_ready_o), 512'd1);
    check_eq("rst_block_valid", 512'(block_valid_o), 512'd0);
    check_eq("rst_block_last", 512'(block_last_o), 512'd0);
    check_eq("rst_block", block_o, 512'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // "abc": valid two cycles after the last accept, exact block contents.
    fill_msg(3, 8'h61, 8'h01);
    send_msg();
    @(negedge clk_i);
    check_eq("abc_pad_cycle_valid", 512'(block_valid_o), 512'd0);
    @(negedge clk_i);
    check_eq("abc_emit_valid", 512'(block_valid_o), 512'd1);
    check_eq("abc_block", block_o, {32'h61626380, 416'h0, 64'h18});
    check_eq("abc_last", 512'(block_last_o), 512'd1);
    drain();

    // Table of messages sent back to back.
    seen0   = blocks_seen;
    exp_sum = 0;
    for (int v = 0; v < 10; v++) begin
      fill_msg(vecs[v].len, vecs[v].seed, vecs[v].step);
      send_msg();
      exp_sum += vecs[v].exp_blocks;
    end
    drain();
    check_eq("table_block_count", 512'(blocks_seen - seen0), 512'(exp_sum));

    // Backpressure on a full 64-byte block.
    block_ready_i = 1'b0;
    fill_msg(64, 8'h40, 8'h01);
    send_msg();
    @(negedge clk_i);
    check_eq("full_block_latency", 512'(block_valid_o), 512'd1);
    check_eq("bp_first_vs_model", block_o, exp_q[0].blk);
    hold_blk  = block_o;
    hold_last = block_last_o;
    @(posedge clk_i);
    #1;
    byte_valid_i = 1'b1;
    byte_i       = 8'hee;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check_eq("bp_block_hold", block_o, hold_blk);
      check_eq("bp_last_hold", 512'(block_last_o), 512'(hold_last));
      check_eq("bp_valid_hold", 512'(block_valid_o), 512'd1);
      check_eq("bp_byte_ready", 512'(byte_ready_o), 512'd0);
      @(posedge clk_i);
      #1;
    end
    byte_valid_i  = 1'b0;
    block_ready_i = 1'b1;
    fill_msg(3, 8'h61, 8'h01);
    send_msg();
    drain();

    // Clear while a block is offered drops it.
    block_ready_i = 1'b0;
    fill_msg(64, 8'h01, 8'h01);
    drive_bytes(1'b0);
    @(negedge clk_i);
    check_eq("pre_clear_valid", 512'(block_valid_o), 512'd1);
    @(posedge clk_i);
    #1;
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    @(negedge clk_i);
    check_eq("clear_valid", 512'(block_valid_o), 512'd0);
    check_eq("clear_byte_ready", 512'(byte_ready_o), 512'd1);
    check_eq("clear_block", block_o, 512'd0);
    @(posedge clk_i);
    #1;
    block_ready_i = 1'b1;

    // Clear after 30 bytes, with a last byte offered in the clear cycle.
    fill_msg(30, 8'h33, 8'h02);
    drive_bytes(1'b0);
    clear_i      = 1'b1;
    byte_valid_i = 1'b1;
    byte_i       = 8'hff;
    byte_last_i  = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    fill_msg(3, 8'h61, 8'h01);
    send_msg();
    drain();

    // Asynchronous reset in the middle of a message.
    fill_msg(10, 8'h07, 8'h01);
    drive_bytes(1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("arst_byte_ready", 512'(byte_ready_o), 512'd1);
    check_eq("arst_block_valid", 512'(block_valid_o), 512'd0);
    check_eq("arst_block", block_o, 512'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    fill_msg(3, 8'h61, 8'h01);
    send_msg();
    drain();

    repeat (3) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
